downsamp_ctrl: RTL and testbench
================================

Name: downsamp_ctrl

Overview:
Sequencer for the decimating down-sampler datapath (sample FIFO -> accumulator -> output register).
- Pops ADC samples from the sample FIFO.
- Drives the accumulator's first/add/last strobes over groups of 2^SAMPLE_RATE samples.
- Runs the output valid/ready handshake with backpressure.
- Runs finite or continuous capture runs under start/abort control and flags FIFO overrun.
- Sits between the ADC-side FIFO and the DOWNSAMP datapath; contains no data-path arithmetic.

Parameters:
SAMPLE_RATE, 4, log2 of decimation factor (group = 2^SAMPLE_RATE samples); 0 is legal (no decimation).
LEN_WIDTH, 16, width of capture_len and out_count.

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run when in IDLE, ignored otherwise
abort  input  1  level; forces return to IDLE, has priority over start
capture_len  input  LEN_WIDTH  decimated outputs per run, latched on accepted start; 0 = continuous
fifo_empty  input  1  sample FIFO empty
fifo_full  input  1  sample FIFO full (overrun detection)
fifo_rd_en  output  1  FIFO pop; read data valid the following cycle
acc_en  output  1  accumulator consumes FIFO data this cycle
acc_first  output  1  with acc_en: load sample instead of add
acc_last  output  1  with acc_en: output register captures final sum this edge
out_valid  output  1  output register holds an unconsumed decimated sample
out_ready  input  1  downstream accepts when out_valid && out_ready
busy  output  1  high in RUN or FLUSH
done  output  1  one-cycle pulse on run completion
overrun  output  1  sticky FIFO-full flag
out_count  output  LEN_WIDTH  acc_last strobes issued in current run

Behaviour:
- Reset (rst_in low, async): state IDLE.
  - All outputs 0; grp_cnt = 0, out_count = 0, latched length = 0.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start && !abort. On that edge: latch capture_len, clear grp_cnt, out_count and overrun.
  - RUN -> FLUSH on the edge issuing the read for the last sample of group number capture_len (capture_len != 0).
  - FLUSH -> DONE when no read is in flight and out_valid is 0, or is handshaking this cycle.
  - DONE -> IDLE unconditionally; done = 1 while in DONE.
  - Any state -> IDLE on abort. out_valid clears, in-flight read is discarded (no acc_en next cycle), partial group is dropped.
- Read issue (RUN only): fifo_rd_en = !fifo_empty && !abort && gate.
  - gate = 1 when grp_cnt != 2^SAMPLE_RATE-1.
  - Otherwise gate = (!out_valid || out_ready). The register is then guaranteed free at capture.
- Read latency 1: a read issued in cycle N gives acc_en = 1 in cycle N+1.
  - acc_first = (grp_cnt at issue == 0); acc_last = (grp_cnt at issue == 2^SAMPLE_RATE-1).
  - With SAMPLE_RATE = 0, both are high on every sample.
- grp_cnt (SAMPLE_RATE bits) increments per issued read and wraps to 0 after 2^SAMPLE_RATE-1.
- out_count increments per issued last-group read and wraps at 2^LEN_WIDTH in continuous mode.
- out_valid: set on the edge ending an acc_last cycle, cleared on the edge ending a cycle with out_valid && out_ready.
  - Set and clear in the same cycle is impossible by the read gate.
- Continuous mode (capture_len = 0): stays in RUN until abort.
- overrun: set on any cycle with busy && fifo_full. Holds until the next accepted start or reset; no effect on sequencing.
- FIFO empty mid-group: reads pause, grp_cnt holds, group continues when data returns.

Test Plan:
- SAMPLE_RATE=4, capture_len=2, FIFO never empty, out_ready=1 -> 32 consecutive fifo_rd_en; acc_first at acc cycles 1 and 17; acc_last at 16 and 32; out_valid 1-cycle pulses; FLUSH then done pulse; out_count=2.
- Same, out_ready=0 for 40 cycles after first out_valid -> 15 reads of group 2, then rd_en held low, out_valid held; reads resume the cycle out_ready rises.
- fifo_empty asserted for 5 cycles after 7th read -> no rd_en/acc_en for 5 cycles, grp_cnt holds at 7; acc_first not reasserted on resume.
- capture_len=0, abort after 50 reads -> busy stays 1 until abort, then IDLE next cycle; out_valid=0, no done pulse, acc_en low the cycle after abort.
- start and abort in same cycle in IDLE -> stays IDLE, busy=0; start while busy -> ignored, capture_len change not latched.
- fifo_full pulsed 1 cycle during RUN -> overrun=1 through DONE; cleared by next start; rst_in low mid-run -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/downsamp_ctrl_if.sv
// downsamp_ctrl_if: FIFO pop, accumulator strobes and output handshake between sequencer and datapath
interface downsamp_ctrl_if;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_rd_en;
    logic acc_en;
    logic acc_first;
    logic acc_last;
    logic out_valid;
    logic out_ready;

    modport master (
        input  fifo_empty, fifo_full, out_ready,
        output fifo_rd_en, acc_en, acc_first, acc_last, out_valid
    );

    modport slave (
        output fifo_empty, fifo_full, out_ready,
        input  fifo_rd_en, acc_en, acc_first, acc_last, out_valid
    );
endinterface

// File: rtl/downsamp_ctrl.sv
// downsamp_ctrl: sequences FIFO pops, accumulator strobes and output handshake for the decimator
module downsamp_ctrl #(
    parameter int SAMPLE_RATE = 4,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] capture_len,
    downsamp_ctrl_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [LEN_WIDTH-1:0] out_count
);
    localparam int GW = SAMPLE_RATE == 0 ? 1 : SAMPLE_RATE;
    localparam logic [GW-1:0] GMAX = GW'((1 << SAMPLE_RATE) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state, state_nx;
    logic [GW-1:0]        grp_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 rd_pend, pend_first, pend_last, ov;
    logic                 grp_end, accept, rd, run_end;

    assign grp_end = grp_cnt == GMAX;
    assign accept  = state == IDLE && start && !abort;
    // the last read of a group waits until the output register is free at capture time
    assign rd      = state == RUN && !bus.fifo_empty && !abort && (!grp_end || !ov || bus.out_ready);
    assign run_end = rd && grp_end && len_q != '0 && out_count == len_q - LEN_WIDTH'(1);

    assign bus.fifo_rd_en = rd;
    assign bus.acc_en     = rd_pend;
    assign bus.acc_first  = pend_first;
    assign bus.acc_last   = pend_last;
    assign bus.out_valid  = ov;
    assign busy           = state == RUN || state == FLUSH;
    assign done           = state == DONE;

    // next-state selection; abort overrides everything
    always_comb begin
        state_nx = state;
        if (abort) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = start ? RUN : IDLE;
                RUN:     state_nx = run_end ? FLUSH : RUN;
                FLUSH:   state_nx = (!rd_pend && (!ov || bus.out_ready)) ? DONE : FLUSH;
                default: state_nx = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else state <= state_nx;
    end

    // run length latch, group position and completed-group count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            len_q     <= '0;
            grp_cnt   <= '0;
            out_count <= '0;
        end else if (accept) begin
            len_q     <= capture_len;
            grp_cnt   <= '0;
            out_count <= '0;
        end else if (rd) begin
            grp_cnt   <= grp_end ? '0 : grp_cnt + GW'(1);
            out_count <= grp_end ? out_count + LEN_WIDTH'(1) : out_count;
        end
    end

    // one-cycle read pipeline carrying first/last tags to the accumulator
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_pend    <= 1'b0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            rd_pend    <= rd;
            pend_first <= rd && grp_cnt == '0;
            pend_last  <= rd && grp_end;
        end
    end

    // output register occupancy: filled by acc_last, drained by handshake, flushed by abort
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) ov <= 1'b0;
        else ov <= abort ? 1'b0 : pend_last ? 1'b1 : (ov && bus.out_ready) ? 1'b0 : ov;
    end

    // sticky overrun, cleared only by a new run
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) overrun <= 1'b0;
        else overrun <= accept ? 1'b0 : (busy && bus.fifo_full) ? 1'b1 : overrun;
    end
endmodule

// File: tb/tb_downsamp_ctrl.sv
// tb_downsamp_ctrl: directed checks of run sequencing, backpressure, stalls, abort, overrun and reset
module tb_downsamp_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start, abort;
    logic [15:0] capture_len;
    logic        busy, done, overrun;
    logic [15:0] out_count;
    int          tests = 0, failed = 0;
    int          rd_cnt, rd_run, rd_max, acc_cnt, ov_cyc, ov_run, ov_max, done_cnt;
    int          first_pos[$], last_pos[$];

    downsamp_ctrl_if bus();

    downsamp_ctrl #(.SAMPLE_RATE(4), .LEN_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .abort(abort),
        .capture_len(capture_len), .bus(bus), .busy(busy), .done(done),
        .overrun(overrun), .out_count(out_count)
    );

    always #5 clk_in = ~clk_in;

    // activity statistics sampled mid-cycle
    always @(negedge clk_in) begin
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            rd_run++;
            if (rd_run > rd_max) rd_max = rd_run;
        end else rd_run = 0;
        if (bus.acc_en) begin
            acc_cnt++;
            if (bus.acc_first) first_pos.push_back(acc_cnt);
            if (bus.acc_last) last_pos.push_back(acc_cnt);
        end
        if (bus.out_valid) begin
            ov_cyc++;
            ov_run++;
            if (ov_run > ov_max) ov_max = ov_run;
        end else ov_run = 0;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr();
        rd_cnt = 0; rd_run = 0; rd_max = 0; acc_cnt = 0;
        ov_cyc = 0; ov_run = 0; ov_max = 0; done_cnt = 0;
        first_pos.delete();
        last_pos.delete();
    endtask

    task automatic run_start(input logic [15:0] len);
        capture_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int i = 0;
        while (!done && i < bound) begin
            tick();
            i++;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_rd(input string tag, input int n, input int bound);
        int i = 0;
        while (rd_cnt < n && i < bound) begin
            tick();
            i++;
        end
        check(tag, rd_cnt, n);
    endtask

    initial begin
        rst_in = 1'b0; start = 1'b0; abort = 1'b0; capture_len = '0;
        bus.fifo_empty = 1'b1; bus.fifo_full = 1'b0; bus.out_ready = 1'b1;
        clr();
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_acc_en", bus.acc_en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out_count", out_count, 0);
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // two full groups, free-flowing
        bus.fifo_empty = 1'b0;
        clr();
        run_start(16'd2);
        wait_done("t1_done", 200);
        check("t1_rd_cnt", rd_cnt, 32);
        check("t1_rd_consec", rd_max, 32);
        check("t1_first_n", first_pos.size(), 2);
        check("t1_first0", first_pos[0], 1);
        check("t1_first1", first_pos[1], 17);
        check("t1_last_n", last_pos.size(), 2);
        check("t1_last0", last_pos[0], 16);
        check("t1_last1", last_pos[1], 32);
        check("t1_ov_cyc", ov_cyc, 2);
        check("t1_ov_pulse", ov_max, 1);
        check("t1_out_count", out_count, 2);
        tick();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_done", done, 0);

        // backpressure on the first output
        clr();
        bus.out_ready = 1'b0;
        run_start(16'd2);
        for (int i = 0; i < 100 && !bus.out_valid; i++) tick();
        check("t2_ov_seen", bus.out_valid, 1);
        repeat (40) tick();
        check("t2_rd_stalled_cnt", rd_cnt, 31);
        check("t2_rd_held_low", bus.fifo_rd_en, 0);
        check("t2_ov_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1;
        check("t2_rd_resume", bus.fifo_rd_en, 1);
        wait_done("t2_done", 100);
        check("t2_rd_cnt", rd_cnt, 32);
        check("t2_out_count", out_count, 2);
        tick();

        // FIFO runs dry mid-group
        clr();
        run_start(16'd1);
        wait_rd("t3_rd7", 7, 50);
        bus.fifo_empty = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_gap_rd_en", bus.fifo_rd_en, 0);
            check("t3_gap_acc_en", bus.acc_en, k == 0);
            tick();
        end
        bus.fifo_empty = 1'b0;
        #1;
        check("t3_resume_rd_en", bus.fifo_rd_en, 1);
        check("t3_resume_acc_en", bus.acc_en, 0);
        check("t3_acc_cnt", acc_cnt, 7);
        wait_done("t3_done", 100);
        check("t3_rd_cnt", rd_cnt, 16);
        check("t3_first_n", first_pos.size(), 1);
        check("t3_last_n", last_pos.size(), 1);
        check("t3_last0", last_pos[0], 16);
        check("t3_out_count", out_count, 1);
        tick();

        // continuous run terminated by abort
        clr();
        run_start(16'd0);
        wait_rd("t4_rd50", 50, 200);
        check("t4_busy_run", busy, 1);
        check("t4_out_count", out_count, 3);
        abort = 1'b1;
        #1;
        check("t4_abort_rd_en", bus.fifo_rd_en, 0);
        tick();
        abort = 1'b0;
        check("t4_post_busy", busy, 0);
        check("t4_post_acc_en", bus.acc_en, 0);
        check("t4_post_ov", bus.out_valid, 0);
        repeat (5) tick();
        check("t4_no_done", done_cnt, 0);
        check("t4_rd_total", rd_cnt, 50);

        // abort discards a held output
        clr();
        bus.out_ready = 1'b0;
        run_start(16'd0);
        wait_rd("t4b_rd31", 31, 100);
        repeat (3) tick();
        check("t4b_ov_held", bus.out_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b1;
        check("t4b_ov_cleared", bus.out_valid, 0);
        check("t4b_busy", busy, 0);

        // start with abort in IDLE is refused
        clr();
        capture_len = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_sa_busy", busy, 0);
        tick();
        check("t5_sa_busy2", busy, 0);
        check("t5_sa_rd", rd_cnt, 0);

        // start while busy is ignored
        clr();
        run_start(16'd1);
        repeat (3) tick();
        capture_len = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_kept", busy, 1);
        wait_done("t5_done", 100);
        check("t5_out_count", out_count, 1);
        check("t5_rd_cnt", rd_cnt, 16);
        tick();

        // overrun stickiness and clearing, then async reset mid-run
        clr();
        run_start(16'd1);
        repeat (4) tick();
        bus.fifo_full = 1'b1;
        tick();
        bus.fifo_full = 1'b0;
        check("t6_ovr_set", overrun, 1);
        wait_done("t6_done", 100);
        check("t6_ovr_in_done", overrun, 1);
        tick();
        check("t6_ovr_idle", overrun, 1);
        clr();
        run_start(16'd3);
        check("t6_ovr_cleared", overrun, 0);
        wait_rd("t6_rd20", 20, 100);
        bus.fifo_full = 1'b1;
        tick();
        bus.fifo_full = 1'b0;
        check("t6_ovr_set2", overrun, 1);
        check("t6_out_count_pre", out_count, 1);
        rst_in = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rd_en", bus.fifo_rd_en, 0);
        check("t6_rst_acc_en", bus.acc_en, 0);
        check("t6_rst_ov", bus.out_valid, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_out_count", out_count, 0);
        check("t6_rst_done", done, 0);
        tick();
        rst_in = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
